// File: rtl/dmem_lsu_if.sv
// Request/response channel between the execute stage and the dmem_lsu data memory.
// The master drives requests and consumes responses; the slave is the memory.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store data memory: byte/half/word access, one outstanding request, fixed latency.
// Define DMEM_ERR_CHECK_EN to report alignment/range/funct3 errors; otherwise accesses are coerced.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request captured, counting down the remaining latency
// RESP  | response held on rsp_* until rsp_ready
module dmem_lsu #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_lsu_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  enter_resp;
    logic                  acc_write;
    logic [2:0]            acc_f3;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  illegal;
    logic [1:0]            size;
    logic [1:0]            byte_off;
    logic                  acc_err;
    logic                  unused_hi;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word, rd_shift, ld_data, ws, wr_word;
    logic [3:0]            be;
    logic                  mem_we;

    // With LATENCY=1 the access happens on the accept edge, so decode straight from the bus.
    always_comb begin
        acc_write = (state_q == IDLE) ? bus.req_write  : write_q;
        acc_f3    = (state_q == IDLE) ? bus.req_funct3 : funct3_q;
        acc_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
        acc_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
        illegal   = (acc_f3 == 3'b011) || (acc_f3[2:1] == 2'b11) || (acc_write && acc_f3[2]);
`ifdef DMEM_ERR_CHECK_EN
        size      = acc_f3[1:0];
        byte_off  = acc_addr[1:0];
        unused_hi = 1'b0;
        acc_err   = illegal
                    || ((size == 2'd1) && acc_addr[0])
                    || ((size == 2'd2) && (acc_addr[1:0] != 2'b00))
                    || (acc_addr[31:ADDR_WIDTH+2] != '0);
`else
        size      = illegal ? 2'd2 : acc_f3[1:0];
        byte_off  = (size == 2'd2) ? 2'b00 :
                    (size == 2'd1) ? {acc_addr[1], 1'b0} : acc_addr[1:0];
        unused_hi = |acc_addr[31:ADDR_WIDTH+2];
        acc_err   = 1'b0;
`endif
        word_idx = acc_addr[ADDR_WIDTH+1:2];
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {byte_off, 3'b000};
        case (size)
            2'd0:    ld_data = {{24{~acc_f3[2] & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    ld_data = {{16{~acc_f3[2] & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
        case (size)
            2'd0:    be = 4'b0001 << byte_off;
            2'd1:    be = 4'b0011 << byte_off;
            default: be = 4'b1111;
        endcase
        ws = acc_wdata << {byte_off, 3'b000};
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = be[i] ? ws[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = 2'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            rdata_d = (acc_write || acc_err) ? 32'h0 : ld_data;
            err_d   = acc_err;
        end
    end

    // Gating with rst_n keeps a request presented during reset from touching the array.
    assign mem_we = enter_resp && acc_write && !acc_err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: a LATENCY=1 and a LATENCY=3 instance checked against a byte-addressed model.
// Honours DMEM_ERR_CHECK_EN the same way the design does.
module tb_dmem_lsu;
    localparam int AW     = 10;
    localparam int DEPTHB = 4 * (1 << AW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if bus1 ();
    dmem_lsu_if bus3 ();

    dmem_lsu #(.ADDR_WIDTH(AW), .LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dmem_lsu #(.ADDR_WIDTH(AW), .LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] ref_mem [2][DEPTHB];

    task automatic drive_req(input int sel, input logic v, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            bus1.req_valid = v; bus1.req_write = wr; bus1.req_funct3 = f3;
            bus1.req_addr = a; bus1.req_wdata = wd;
        end else begin
            bus3.req_valid = v; bus3.req_write = wr; bus3.req_funct3 = f3;
            bus3.req_addr = a; bus3.req_wdata = wd;
        end
    endtask

    task automatic drive_rready(input int sel, input logic r);
        if (sel == 0) bus1.rsp_ready = r;
        else          bus3.rsp_ready = r;
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? bus1.req_ready : bus3.req_ready;
    endfunction
    function automatic logic get_vld(input int sel);
        return (sel == 0) ? bus1.rsp_valid : bus3.rsp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus1.rsp_rdata : bus3.rsp_rdata;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus1.rsp_err : bus3.rsp_err;
    endfunction

    // Reference: memory as a flat byte array, access size in bytes, extension by arithmetic.
    function automatic void model(input int sel, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int nb;
        int ba;
        logic ill;
        logic [31:0] v;
        ill = (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3 >= 3'd4);
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        rd  = 32'h0;
        er  = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        er = ill || ((a % nb) != 0) || (a >= DEPTHB);
        ba = int'(a % DEPTHB);
`else
        if (ill) nb = 4;
        ba = int'(a % DEPTHB);
        ba = ba - (ba % nb);
`endif
        if (er) return;
        if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[sel][ba + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[sel][ba + i]) << (8 * i));
            if (f3 < 3'd4 && nb < 4 && v[8*nb - 1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
            rd = v;
        end
    endfunction

    // Runs one transaction; returns observations and the model's expectations for the caller to compare.
    task automatic do_txn(input int sel, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic hold_ok, output logic post_ok,
                          output logic [31:0] exp_rd, output logic exp_er);
        int k;
        @(negedge clk);
        k = 0;
        while (!get_rdy(sel) && k < 50) begin @(negedge clk); k++; end
        drive_req(sel, 1'b1, wr, f3, a, wd);
        drive_rready(sel, 1'b0);
        @(negedge clk);
        drive_req(sel, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        model(sel, wr, f3, a, wd, exp_rd, exp_er);
        lat = 1;
        hold_ok = 1'b1;
        while (!get_vld(sel) && lat < 20) begin
            if (get_rdy(sel)) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (get_rdy(sel)) hold_ok = 1'b0;
        rd = get_rdata(sel);
        er = get_err(sel);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (get_rdata(sel) !== rd || get_err(sel) !== er || !get_vld(sel) || get_rdy(sel))
                hold_ok = 1'b0;
        end
        drive_rready(sel, 1'b1);
        @(negedge clk);
        post_ok = !get_vld(sel) && get_rdy(sel);
        drive_rready(sel, 1'b0);
    endtask

    task automatic test_reset();
        drive_req(0, 1'b1, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF);
        drive_req(1, 1'b1, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF);
        drive_rready(0, 1'b1);
        drive_rready(1, 1'b1);
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_err} !== 3'b100 || bus1.rsp_rdata !== 32'h0)
            $display("FAIL reset_dut1 got rdy/vld/err=%b%b%b rdata=%h exp 100 rdata=0",
                     bus1.req_ready, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata);
        else n_pass++;
        n_total++;
        if ({bus3.req_ready, bus3.rsp_valid, bus3.rsp_err} !== 3'b100 || bus3.rsp_rdata !== 32'h0)
            $display("FAIL reset_dut3 got rdy/vld/err=%b%b%b rdata=%h exp 100 rdata=0",
                     bus3.req_ready, bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata);
        else n_pass++;
        drive_req(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive_rready(0, 1'b0);
        drive_rready(1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus1.rsp_valid !== 1'b0 || bus3.rsp_valid !== 1'b0)
            $display("FAIL reset_release got vld1=%b vld3=%b exp 0 0", bus1.rsp_valid, bus3.rsp_valid);
        else n_pass++;
    endtask

    task automatic init_mem();
        logic [31:0] rd, erd;
        logic er, eer, hok, pok;
        int lat;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++)
                do_txn(s, 1'b1, 3'd2, 32'(w * 4), $urandom, 0, rd, er, lat, hok, pok, erd, eer);
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd;
        logic er, eer, hok, pok;
        int lat;
        do_txn(0, 1'b1, 3'd2, 32'h4, 32'hDEAD_BEEF, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (lat !== 1 || rd !== 32'h0 || er !== 1'b0 || !pok)
            $display("FAIL sw_deadbeef got lat=%0d rdata=%h err=%b post=%b exp lat=1 rdata=0 err=0 post=1", lat, rd, er, pok);
        else n_pass++;
        do_txn(0, 1'b0, 3'd2, 32'h4, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (lat !== 1 || rd !== 32'hDEAD_BEEF || er !== 1'b0)
            $display("FAIL lw_deadbeef got lat=%0d rdata=%h err=%b exp lat=1 rdata=deadbeef err=0", lat, rd, er);
        else n_pass++;
        do_txn(0, 1'b1, 3'd0, 32'h5, 32'h1234_56AB, 0, rd, er, lat, hok, pok, erd, eer);
        do_txn(0, 1'b0, 3'd2, 32'h4, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'hDEAD_ABEF) $display("FAIL sb_then_lw got %h exp deadabef", rd);
        else n_pass++;
        do_txn(0, 1'b0, 3'd0, 32'h5, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'hFFFF_FFAB) $display("FAIL lb got %h exp ffffffab", rd);
        else n_pass++;
        do_txn(0, 1'b0, 3'd4, 32'h5, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'h0000_00AB) $display("FAIL lbu got %h exp 000000ab", rd);
        else n_pass++;
        do_txn(0, 1'b0, 3'd1, 32'h6, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'hFFFF_DEAD) $display("FAIL lh got %h exp ffffdead", rd);
        else n_pass++;
        do_txn(0, 1'b0, 3'd5, 32'h6, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'h0000_DEAD) $display("FAIL lhu got %h exp 0000dead", rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer, hok, pok;
        int lat;
`ifdef DMEM_ERR_CHECK_EN
        do_txn(0, 1'b0, 3'd1, 32'h3, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lh_misaligned got err=%b rdata=%h exp err=1 rdata=0", er, rd);
        else n_pass++;
        do_txn(0, 1'b1, 3'd2, 32'h2, 32'h1234_5678, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (er !== 1'b1) $display("FAIL sw_misaligned got err=%b exp 1", er);
        else n_pass++;
        do_txn(0, 1'b0, 3'd2, 32'h0, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== erd || er !== 1'b0) $display("FAIL lw_after_bad_sw got %h err=%b exp %h err=0", rd, er, erd);
        else n_pass++;
        do_txn(0, 1'b0, 3'd2, 32'h1004, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (er !== 1'b1 || rd !== 32'h0) $display("FAIL out_of_range got err=%b rdata=%h exp err=1 rdata=0", er, rd);
        else n_pass++;
        do_txn(0, 1'b0, 3'd3, 32'h4, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (er !== 1'b1) $display("FAIL funct3_011 got err=%b exp 1", er);
        else n_pass++;
`else
        do_txn(0, 1'b0, 3'd2, 32'h7, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'hDEAD_ABEF || er !== 1'b0) $display("FAIL lw_align_down got %h err=%b exp deadabef err=0", rd, er);
        else n_pass++;
        do_txn(0, 1'b0, 3'd2, 32'h1004, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'hDEAD_ABEF || er !== 1'b0) $display("FAIL lw_wrap got %h err=%b exp deadabef err=0", rd, er);
        else n_pass++;
        do_txn(0, 1'b0, 3'd1, 32'h7, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'hFFFF_DEAD) $display("FAIL lh_align_down got %h exp ffffdead", rd);
        else n_pass++;
        do_txn(0, 1'b0, 3'd3, 32'h4, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'hDEAD_ABEF || er !== 1'b0) $display("FAIL funct3_011_as_w got %h err=%b exp deadabef err=0", rd, er);
        else n_pass++;
`endif
    endtask

    task automatic test_latency();
        logic [31:0] rd, erd;
        logic er, eer, hok, pok;
        int lat;
        do_txn(1, 1'b1, 3'd2, 32'h10, 32'hCAFE_F00D, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (lat !== 3 || !pok) $display("FAIL lat3_sw got lat=%0d post=%b exp lat=3 post=1", lat, pok);
        else n_pass++;
        do_txn(1, 1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (lat !== 3 || rd !== 32'hCAFE_F00D || er !== 1'b0)
            $display("FAIL lat3_lw got lat=%0d rdata=%h err=%b exp lat=3 rdata=cafef00d err=0", lat, rd, er);
        else n_pass++;
        n_total++;
        if (!hok || !pok) $display("FAIL lat3_hold got hold=%b post=%b exp 1 1", hok, pok);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int accepts;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            drive_req(s, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
            drive_rready(s, 1'b1);
            accepts = 0;
            for (int c = 0; c < 20; c++) begin
                if (get_rdy(s)) accepts++;
                @(negedge clk);
            end
            drive_req(s, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            repeat (5) @(negedge clk);
            drive_rready(s, 1'b0);
            n_total++;
            if (accepts !== ((s == 0) ? 10 : 5))
                $display("FAIL back_to_back sel=%0d got %0d accepts exp %0d", s, accepts, (s == 0) ? 10 : 5);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, erd;
        logic er, eer, hok, pok;
        int lat, k;
        do_txn(1, 1'b1, 3'd2, 32'h8, 32'h2222_2222, 0, rd, er, lat, hok, pok, erd, eer);
        @(negedge clk);
        drive_req(1, 1'b1, 1'b1, 3'd2, 32'h8, 32'h1111_1111);
        @(negedge clk);
        drive_req(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        n_total++;
        if (bus3.req_ready !== 1'b0 || bus3.rsp_valid !== 1'b0)
            $display("FAIL abort_in_wait got rdy=%b vld=%b exp 0 0", bus3.req_ready, bus3.rsp_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus3.req_ready !== 1'b1 || bus3.rsp_valid !== 1'b0)
            $display("FAIL abort_immediate got rdy=%b vld=%b exp 1 0", bus3.req_ready, bus3.rsp_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1, 1'b0, 3'd2, 32'h8, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'h2222_2222) $display("FAIL abort_no_write got %h exp 22222222", rd);
        else n_pass++;
        @(negedge clk);
        drive_req(1, 1'b1, 1'b1, 3'd2, 32'h8, 32'h3333_3333);
        @(negedge clk);
        drive_req(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        k = 0;
        while (!bus3.rsp_valid && k < 20) begin @(negedge clk); k++; end
        model(1, 1'b1, 3'd2, 32'h8, 32'h3333_3333, erd, eer);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (k >= 20 || bus3.rsp_valid !== 1'b0)
            $display("FAIL abort_in_resp got vld=%b waited=%0d exp vld=0 waited<20", bus3.rsp_valid, k);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1, 1'b0, 3'd2, 32'h8, 32'h0, 0, rd, er, lat, hok, pok, erd, eer);
        n_total++;
        if (rd !== 32'h3333_3333) $display("FAIL resp_store_kept got %h exp 33333333", rd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a;
        logic er, eer, hok, pok, wr;
        logic [2:0] f3;
        int lat;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 150; n++) begin
                wr = 1'($urandom % 2);
                f3 = 3'($urandom % 8);
                a  = 32'($urandom % 64);
                if ($urandom % 8 == 0) a = a | (32'($urandom_range(1, 7)) << 12);
                do_txn(s, wr, f3, a, $urandom, int'($urandom % 3), rd, er, lat, hok, pok, erd, eer);
                n_total++;
                if (rd !== erd || er !== eer || lat !== ((s == 0) ? 1 : 3) || !hok || !pok)
                    $display("FAIL rand sel=%0d wr=%b f3=%0d addr=%h got rdata=%h err=%b lat=%0d hold=%b post=%b exp rdata=%h err=%b",
                             s, wr, f3, a, rd, er, lat, hok, pok, erd, eer);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        drive_req(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive_rready(0, 1'b0);
        drive_rready(1, 1'b0);
        test_reset();
        init_mem();
        test_basic();
        test_errors();
        test_latency();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised load/store data memory for the RV32I core, successor to the single-cycle word-only `data_mem`. It accepts one request at a time over a valid/ready handshake and supports byte, halfword and word loads and stores selected by RV32I `funct3`, with sign or zero extension on loads. Access latency is configurable. Alignment and range errors are reported on the response channel. It sits between the execute stage and the writeback mux, replacing the direct `mem_read`/`mem_write` strobes.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 1: cycles from request accept to `rsp_valid`; legal range 1..4.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, LSB-aligned
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes the response
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  access error (see Configuration)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, capture write, funct3, addr and wdata, then:
  - if LATENCY=1, go to RESP;
  - otherwise load a countdown with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. At 1, go to RESP.
- The array access happens on the edge that enters RESP.
- RESP: `rsp_valid`=1 and outputs are held stable. On `rsp_ready`=1, go to IDLE.
- Byte lanes are selected by `addr[1:0]`:
  - SB writes `wdata[7:0]` to the selected byte.
  - SH writes `wdata[15:0]` to bytes {1,0} or {3,2}.
  - SW writes all four bytes.
  - Unselected bytes are preserved.
- Loads:
  - LB and LH sign-extend from bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - LW returns the full word.
- Error conditions:
  - LH, LHU or SH with `addr[0]`=1.
  - LW or SW with `addr[1:0]`≠0.
  - `addr[31:ADDR_WIDTH+2]`≠0.
  - Illegal funct3: 011, 11x, or store with 1xx.
- Response on error: `rsp_err`=1, `rsp_rdata`=0, and the memory is not modified.
- Store response: `rsp_rdata`=0, `rsp_err` per the error checks.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0. Memory contents are not reset.
- While `rst_n`=0, requests are ignored.
- Reset asserted during WAIT or RESP aborts the operation immediately:
  - a pending store that has not yet entered RESP is not written;
  - a store already in RESP is kept.
- Request accepted at edge N: `rsp_valid` rises after edge N+LATENCY.
- `req_ready` is low from edge N+1 until the edge following the `rsp_valid && rsp_ready` handshake.
- Peak throughput is one request per LATENCY+1 cycles.
- `rsp_ready` held low keeps RESP indefinitely with stable outputs and `req_ready` low.
- `req_valid` during WAIT or RESP is not accepted. The requester must hold the request until it sees `req_ready`.
- Only one request is outstanding; there is no request queue.

## Configuration
- Macro `DMEM_ERR_CHECK_EN`.
- Defined: error detection as specified above.
- Undefined:
  - `rsp_err` is tied to 0.
  - Misaligned H and W addresses are aligned down (`addr[0]` or `addr[1:0]` forced to 0).
  - Out-of-range addresses wrap modulo the depth.
  - Illegal funct3 is treated as W.

## Test plan
- SW 0xDEADBEEF to 0x4, then LW 0x4 (LATENCY=1) -> `rsp_valid` one cycle after each accept; load returns 0xDEADBEEF with `rsp_err`=0.
- After the above, SB 0xAB to 0x5, then:
  - LW 0x4 -> 0xDEADABEF;
  - LB 0x5 -> 0xFFFFFFAB;
  - LBU 0x5 -> 0x000000AB;
  - LH 0x6 -> 0xFFFFDEAD.
- With `DMEM_ERR_CHECK_EN`:
  - LH 0x3 -> `rsp_err`=1, rdata 0;
  - SW 0x2 of 0x12345678 -> `rsp_err`=1, and a following LW 0x0 is unchanged.
- LATENCY=3, `rsp_ready` low for 5 cycles -> `rsp_valid` rises 3 cycles after accept; `req_ready` stays low and outputs are stable until `rsp_ready`; `req_ready` returns the cycle after.
- `rst_n` pulsed low during WAIT of an SW 0x11111111 to 0x8 -> immediate IDLE, `rsp_valid`=0, `req_ready`=1; a later LW 0x8 returns the prior value.
- Without `DMEM_ERR_CHECK_EN`, LW 0x7 -> returns the word at 0x4, `rsp_err`=0.
